// File: rtl/uart_tx_arbiter_if.sv
`default_nettype none
// ============================================================================
// uart_tx_arbiter_if : request/byte bus between four requesters and the
//                      shared UART transmitter scheduler.
// Revision 1.0
// ============================================================================
interface uart_tx_arbiter_if #(
  parameter int DIV_W = 32
);
  logic [3:0]       req;
  logic [31:0]      req_data;
  logic [DIV_W-1:0] baud_div;
  logic [3:0]       grant;
  logic [3:0]       done;
  logic             busy;
  logic [1:0]       active_id;
  logic [7:0]       tx_data;
  logic             tx_start;

  modport slave (
    input  req, req_data, baud_div,
    output grant, done, busy, active_id, tx_data, tx_start
  );

  modport master (
    output req, req_data, baud_div,
    input  grant, done, busy, active_id, tx_data, tx_start
  );
endinterface
`default_nettype wire

// File: rtl/uart_tx_arbiter.sv
`default_nettype none
// ============================================================================
// uart_tx_arbiter : round-robin scheduler sharing one UART TX among four
//                   requesters; times each frame from the latched divider.
// Revision 1.0
// ============================================================================
module uart_tx_arbiter #(
  parameter int FRAME_BITS = 11,
  parameter int DIV_W      = 32
) (
  input wire logic          clk,
  input wire logic          rst_n,
  uart_tx_arbiter_if.slave  bus
);
  localparam int BIT_W = $clog2(FRAME_BITS);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_LOAD = 3'd1,
    S_SEND = 3'd2,
    S_WAIT = 3'd3,
    S_DONE = 3'd4
  } state_t;

  state_t           state_q, state_d;
  logic [1:0]       ptr_q, ptr_d;
  logic [1:0]       active_id_q, active_id_d;
  logic [3:0]       grant_q, grant_d;
  logic [3:0]       done_q, done_d;
  logic             busy_q, busy_d;
  logic             tx_start_q, tx_start_d;
  logic [7:0]       tx_data_q, tx_data_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [DIV_W-1:0] period_q, period_d;
  logic [BIT_W-1:0] bit_q, bit_d;

  logic             found;
  logic [1:0]       win;
  logic [1:0]       idx;
  logic [4:0]       sel;

  // Round-robin search starting at the pointer, wrapping modulo 4.
  always_comb begin
    found = 1'b0;
    win   = ptr_q;
    idx   = 2'd0;
    for (int k = 0; k < 4; k++) begin
      idx = ptr_q + 2'(k);
      if (!found && bus.req[idx]) begin
        found = 1'b1;
        win   = idx;
      end
    end
    sel = {win, 3'b000};
  end

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    active_id_d = active_id_q;
    grant_d     = 4'b0000;
    done_d      = 4'b0000;
    busy_d      = busy_q;
    tx_start_d  = 1'b0;
    tx_data_d   = tx_data_q;
    div_d       = div_q;
    period_d    = period_q;
    bit_d       = bit_q;

    case (state_q)
      S_IDLE: begin
        if (found) begin
          grant_d     = 4'b0001 << win;
          tx_data_d   = bus.req_data[sel +: 8];
          active_id_d = win;
          div_d       = (bus.baud_div == '0) ? DIV_W'(1) : bus.baud_div;
          ptr_d       = win + 2'd1;
          busy_d      = 1'b1;
          state_d     = S_LOAD;
        end
      end
      S_LOAD: begin
        tx_start_d = 1'b1;
        state_d    = S_SEND;
      end
      S_SEND: begin
        period_d = '0;
        bit_d    = '0;
        state_d  = S_WAIT;
      end
      S_WAIT: begin
        if (period_q == div_q - DIV_W'(1)) begin
          period_d = '0;
          if (bit_q == BIT_W'(FRAME_BITS - 1)) begin
            bit_d   = '0;
            done_d  = 4'b0001 << active_id_q;
            state_d = S_DONE;
          end else begin
            bit_d = bit_q + BIT_W'(1);
          end
        end else begin
          period_d = period_q + DIV_W'(1);
        end
      end
      S_DONE: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      ptr_q       <= 2'd0;
      active_id_q <= 2'd0;
      grant_q     <= 4'b0000;
      done_q      <= 4'b0000;
      busy_q      <= 1'b0;
      tx_start_q  <= 1'b0;
      tx_data_q   <= 8'h00;
      div_q       <= '0;
      period_q    <= '0;
      bit_q       <= '0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      active_id_q <= active_id_d;
      grant_q     <= grant_d;
      done_q      <= done_d;
      busy_q      <= busy_d;
      tx_start_q  <= tx_start_d;
      tx_data_q   <= tx_data_d;
      div_q       <= div_d;
      period_q    <= period_d;
      bit_q       <= bit_d;
    end
  end

  assign bus.grant     = grant_q;
  assign bus.done      = done_q;
  assign bus.busy      = busy_q;
  assign bus.active_id = active_id_q;
  assign bus.tx_data   = tx_data_q;
  assign bus.tx_start  = tx_start_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_arbiter.sv
`default_nettype none
// ============================================================================
// tb_uart_tx_arbiter : scenario tasks plus a frame-timing reference model.
// Revision 1.0
// ============================================================================
module tb_uart_tx_arbiter;
  localparam int FB = 11;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;

  uart_tx_arbiter_if #(.DIV_W(32)) bus ();
  uart_tx_arbiter #(.FRAME_BITS(FB), .DIV_W(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Model: a frame granted at cycle g owns the TX until g+2+FB*D; IDLE resumes at g+3+FB*D.
  int          m_idle, m_g, m_d, m_ptr, m_owner;
  logic [7:0]  m_tx;
  logic [3:0]  e_grant;
  logic [19:0] exp_v;

  function automatic logic [19:0] dut_v();
    return {bus.grant, bus.done, bus.busy, bus.active_id, bus.tx_data, bus.tx_start};
  endfunction

  function automatic int oh_idx(input logic [3:0] v);
    int r;
    r = -1;
    for (int i = 0; i < 4; i++) if (v[i]) r = i;
    return r;
  endfunction

  task automatic model_reset();
    m_idle = -1; m_g = -1000000; m_d = 1; m_ptr = 0; m_owner = 0;
    m_tx = 8'h00; e_grant = 4'b0; exp_v = '0;
  endtask

  task automatic model_step();
    int n, w;
    bit f;
    logic [3:0] ed;
    n = cyc + 1;
    if (cyc >= m_idle && bus.req != 4'b0000) begin
      f = 1'b0; w = 0;
      for (int k = 0; k < 4; k++)
        if (!f && bus.req[(m_ptr + k) % 4]) begin f = 1'b1; w = (m_ptr + k) % 4; end
      m_g     = n;
      m_owner = w;
      m_d     = (bus.baud_div == 0) ? 1 : int'(bus.baud_div);
      m_tx    = bus.req_data[8*w +: 8];
      m_ptr   = (w + 1) % 4;
      m_idle  = n + 3 + FB * m_d;
    end
    e_grant = (n == m_g) ? 4'(1 << m_owner) : 4'b0;
    ed      = (n == m_g + 2 + FB * m_d) ? 4'(1 << m_owner) : 4'b0;
    exp_v   = {e_grant, ed, (n >= m_g && n <= m_g + 2 + FB * m_d), 2'(m_owner), m_tx, (n == m_g + 1)};
  endtask

  task automatic tick();
    if (!rst_n) model_reset(); else model_step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) tick();
    checks++; if (bus.grant !== 4'b0) begin errors++; $display("FAIL reset_grant got %b want 0000", bus.grant); end
    checks++; if (bus.done !== 4'b0) begin errors++; $display("FAIL reset_done got %b want 0000", bus.done); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", bus.busy); end
    checks++; if (bus.tx_start !== 1'b0) begin errors++; $display("FAIL reset_tx_start got %b want 0", bus.tx_start); end
    checks++; if (bus.tx_data !== 8'h00) begin errors++; $display("FAIL reset_tx_data got %h want 00", bus.tx_data); end
    checks++; if (bus.active_id !== 2'd0) begin errors++; $display("FAIL reset_active_id got %0d want 0", bus.active_id); end
    rst_n = 1'b1;
    repeat (3) tick();
    checks++; if (dut_v() !== 20'h0) begin errors++; $display("FAIL idle_after_reset got %h want 00000", dut_v()); end
  endtask

  task automatic test_fairness();
    int ids[$];
    int gc[$];
    int owner, exp_id;
    owner = -1;
    bus.baud_div = 1; bus.req_data = $urandom(); bus.req = 4'hF;
    for (int t = 0; t < 100; t++) begin
      tick();
      checks++; if (dut_v() !== exp_v) begin errors++; $display("FAIL fair_cycle cyc %0d got %h want %h", cyc, dut_v(), exp_v); end
      if (bus.done != 4'b0) begin
        checks++;
        if (owner < 0 || bus.done !== 4'(1 << owner)) begin errors++; $display("FAIL fair_done got %b owner %0d", bus.done, owner); end
      end
      if (bus.grant != 4'b0) begin
        owner = oh_idx(bus.grant);
        ids.push_back(owner); gc.push_back(cyc);
        if (ids.size() == 5) bus.req = 4'h0;
      end
    end
    bus.req = 4'h0;
    checks++; if (ids.size() != 5) begin errors++; $display("FAIL fair_count got %0d want 5", ids.size()); end
    for (int k = 0; k < 5 && k < ids.size(); k++) begin
      exp_id = k % 4;
      checks++; if (ids[k] != exp_id) begin errors++; $display("FAIL fair_order[%0d] got %0d want %0d", k, ids[k], exp_id); end
      if (k > 0) begin
        checks++; if (gc[k] - gc[k-1] != 15) begin errors++; $display("FAIL fair_spacing[%0d] got %0d want 15", k, gc[k] - gc[k-1]); end
      end
    end
  endtask

  task automatic test_single();
    int c0;
    logic [31:0] d;
    d = $urandom(); d[15:8] = 8'h0A;
    bus.baud_div = 10; bus.req_data = d; bus.req = 4'b0010;
    c0 = cyc;
    for (int t = 0; t < 120; t++) begin
      tick();
      checks++; if (dut_v() !== exp_v) begin errors++; $display("FAIL single_cycle cyc %0d got %h want %h", cyc, dut_v(), exp_v); end
      checks++; if (bus.busy !== (cyc >= c0 + 1 && cyc <= c0 + 113)) begin errors++; $display("FAIL single_busy cyc %0d got %b", cyc - c0, bus.busy); end
      if (cyc == c0 + 1) begin
        checks++; if (bus.grant !== 4'b0010 || bus.tx_data !== 8'h0A) begin errors++; $display("FAIL single_grant got %b/%h want 0010/0a", bus.grant, bus.tx_data); end
        bus.req = 4'b0;
      end
      if (cyc == c0 + 2) begin
        checks++; if (bus.tx_start !== 1'b1) begin errors++; $display("FAIL single_tx_start got %b want 1", bus.tx_start); end
      end
      if (cyc == c0 + 113) begin
        checks++; if (bus.done !== 4'b0010) begin errors++; $display("FAIL single_done got %b want 0010", bus.done); end
      end
    end
  endtask

  task automatic test_ptr_wrap();
    int ids[$];
    bus.baud_div = 1; bus.req_data = $urandom(); bus.req = 4'b1000;
    for (int t = 0; t < 80; t++) begin
      tick();
      checks++; if (dut_v() !== exp_v) begin errors++; $display("FAIL wrap_cycle cyc %0d got %h want %h", cyc, dut_v(), exp_v); end
      if (bus.grant != 4'b0) begin
        ids.push_back(oh_idx(bus.grant));
        if (ids.size() == 1) bus.req = 4'b1001;
        if (ids.size() == 3) bus.req = 4'b0000;
      end
    end
    bus.req = 4'b0;
    checks++;
    if (ids.size() != 3 || ids[0] != 3 || ids[1] != 0 || ids[2] != 3) begin
      errors++; $display("FAIL wrap_order got %p want 3,0,3", ids);
    end
  endtask

  task automatic test_div_edge();
    int c0;
    bus.baud_div = 0; bus.req_data = $urandom(); bus.req = 4'b0001;
    c0 = cyc;
    for (int t = 0; t < 20; t++) begin
      tick();
      checks++; if (dut_v() !== exp_v) begin errors++; $display("FAIL div0_cycle cyc %0d got %h want %h", cyc, dut_v(), exp_v); end
      if (cyc == c0 + 1) bus.req = 4'b0;
      if (cyc == c0 + 14) begin
        checks++; if (bus.done !== 4'b0001) begin errors++; $display("FAIL div0_done got %b want 0001", bus.done); end
      end
    end
    bus.baud_div = 10; bus.req = 4'b0001;
    c0 = cyc;
    for (int t = 0; t < 120; t++) begin
      tick();
      checks++; if (dut_v() !== exp_v) begin errors++; $display("FAIL divchg_cycle cyc %0d got %h want %h", cyc, dut_v(), exp_v); end
      if (cyc == c0 + 1) bus.req = 4'b0;
      if (cyc == c0 + 50) bus.baud_div = 2;
      if (cyc == c0 + 113) begin
        checks++; if (bus.done !== 4'b0001) begin errors++; $display("FAIL divchg_done got %b want 0001", bus.done); end
      end
    end
  endtask

  task automatic test_cancel();
    int c0, grants;
    grants = 0;
    bus.baud_div = 2; bus.req = 4'b0001;
    c0 = cyc;
    for (int t = 0; t < 40; t++) begin
      tick();
      checks++; if (dut_v() !== exp_v) begin errors++; $display("FAIL cancel_cycle cyc %0d got %h want %h", cyc, dut_v(), exp_v); end
      if (bus.grant != 4'b0) grants++;
      if (cyc == c0 + 1) bus.req = 4'b0;
      if (cyc == c0 + 5) bus.req = 4'b0100;
      if (cyc == c0 + 6) bus.req = 4'b0;
    end
    checks++; if (grants != 1) begin errors++; $display("FAIL cancel_grants got %0d want 1", grants); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL cancel_idle busy got %b want 0", bus.busy); end
  endtask

  task automatic test_reset_mid();
    int c0, c1, dones;
    logic [31:0] d;
    dones = 0;
    d = $urandom();
    bus.baud_div = 10; bus.req_data = d; bus.req = 4'b0010;
    c0 = cyc;
    while (cyc < c0 + 50) begin
      tick();
      checks++; if (dut_v() !== exp_v) begin errors++; $display("FAIL rmid_cycle cyc %0d got %h want %h", cyc, dut_v(), exp_v); end
      if (cyc == c0 + 1) bus.req = 4'b0;
      if (cyc == c0 + 10) bus.req = 4'b0100;
    end
    rst_n = 1'b0;
    #1;
    checks++; if (dut_v() !== 20'h0) begin errors++; $display("FAIL rmid_async got %h want 00000", dut_v()); end
    tick();
    checks++; if (dut_v() !== 20'h0) begin errors++; $display("FAIL rmid_held got %h want 00000", dut_v()); end
    rst_n = 1'b1;
    c1 = cyc;
    for (int t = 0; t < 120; t++) begin
      tick();
      checks++; if (dut_v() !== exp_v) begin errors++; $display("FAIL rmid_after cyc %0d got %h want %h", cyc, dut_v(), exp_v); end
      if (bus.done != 4'b0) dones++;
      if (cyc == c1 + 1) begin
        checks++; if (bus.grant !== 4'b0100 || bus.tx_data !== d[23:16]) begin errors++; $display("FAIL rmid_grant got %b/%h want 0100/%h", bus.grant, bus.tx_data, d[23:16]); end
        bus.req = 4'b0;
      end
      if (cyc == c1 + 113) begin
        checks++; if (bus.done !== 4'b0100) begin errors++; $display("FAIL rmid_done got %b want 0100", bus.done); end
      end
    end
    checks++; if (dones != 1) begin errors++; $display("FAIL rmid_done_count got %0d want 1", dones); end
  endtask

  task automatic test_random();
    logic [3:0]  pend;
    logic [31:0] data;
    pend = 4'b0; data = $urandom();
    bus.baud_div = $urandom_range(0, 3);
    for (int t = 0; t < 3000; t++) begin
      tick();
      checks++; if (dut_v() !== exp_v) begin errors++; $display("FAIL rand_cycle cyc %0d got %h want %h", cyc, dut_v(), exp_v); end
      if ($urandom_range(0, 199) == 0) bus.baud_div = $urandom_range(0, 3);
      for (int i = 0; i < 4; i++) begin
        if (e_grant[i]) begin
          pend[i] = 1'($urandom_range(0, 1));
          if (pend[i]) data[8*i +: 8] = 8'($urandom());
        end else if (!pend[i]) begin
          if ($urandom_range(0, 7) == 0) begin pend[i] = 1'b1; data[8*i +: 8] = 8'($urandom()); end
        end else if ($urandom_range(0, 63) == 0) begin
          pend[i] = 1'b0;
        end
      end
      bus.req = pend; bus.req_data = data;
    end
    bus.req = 4'b0;
    for (int t = 0; t < 50; t++) begin
      tick();
      checks++; if (dut_v() !== exp_v) begin errors++; $display("FAIL rand_drain cyc %0d got %h want %h", cyc, dut_v(), exp_v); end
    end
  endtask

  initial begin
    bus.req = 4'b0; bus.req_data = 32'h0; bus.baud_div = 32'd1;
    model_reset();
    test_reset();
    test_fairness();
    test_single();
    test_ptr_wrap();
    test_div_edge();
    test_cancel();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Round-robin scheduler that shares one UART transmitter between four byte-producing requesters. It accepts a byte from the winning requester and presents it on the transmitter's data input, then issues the start trigger. It times the full frame (start, 8 data, parity, stop) from the programmed baud divider and signals completion to the owner before granting the next requester. It sits between the client logic and the UART TX datapath, on the same `clk` as the transmitter.

## Interface
Parameters:
- `FRAME_BITS`, 11, bit periods per frame (start + 8 data + parity + stop).
- `DIV_W`, 32, width of the baud divider.

Ports:
- `clk`  in  1  system clock, rising edge.
- `rst_n`  in  1  reset; asynchronous, active-low.
- `req`  in  4  per-requester request; bit i high = requester i has a byte.
- `req_data`  in  32  requester i byte on bits [8i+7:8i].
- `baud_div`  in  DIV_W  clk cycles per bit period; 0 is treated as 1.
- `grant`  out  4  one-hot, one-cycle pulse: byte of requester i accepted.
- `done`  out  4  one-hot, one-cycle pulse: requester i's frame finished.
- `busy`  out  1  high from grant cycle through done cycle inclusive.
- `active_id`  out  2  index of the current owner; holds the last owner when idle.
- `tx_data`  out  8  byte to transmitter, stable from grant until the next grant.
- `tx_start`  out  1  one-cycle trigger pulse to the transmitter; the transmitter acts on its rising edge.

## Operation
- FSM states: IDLE → LOAD → SEND → WAIT → DONE → IDLE.
- IDLE: if any `req` bit is high, pick the winner and go to LOAD. Otherwise stay in IDLE.
- Winner selection: search from `ptr` upward, modulo 4. The first set `req` bit wins.
- `ptr` = last granted index + 1 (mod 4). `ptr` resets to 0, so requester 0 has top priority after reset.
- LOAD:
  - `grant[id]`=1.
  - Latch `req_data` of the winner into `tx_data`.
  - Set `active_id`.
  - Latch the effective divider D = max(`baud_div`,1).
  - Update `ptr`.
- SEND: `tx_start`=1 for exactly this cycle.
- WAIT: lasts exactly FRAME_BITS*D cycles, using a bit-period counter 0..D-1 and a bit counter 0..FRAME_BITS-1.
- DONE: `done[active_id]`=1 for one cycle, then go to IDLE.
- Requester contract: hold `req` and `req_data` stable until `grant`. `req` still high in the cycle after `grant` counts as a new request for the next round.
- `req` changes after LOAD have no effect on the frame in progress.
- Dropping `req` before `grant` cancels that request; no grant is issued.
- Changes to `baud_div` mid-frame are ignored. The latched D applies until DONE.
- At most one `grant`, `done` and `tx_start` bit is high in any cycle. `grant` and `done` are never high in the same cycle.

## Timing
- Reset values (asserted immediately, asynchronously):
  - state IDLE, `ptr`=0.
  - `grant`=0, `done`=0, `busy`=0, `tx_start`=0.
  - `tx_data`=0, `active_id`=0.
  - All counters 0.
- Reset mid-frame: the frame is abandoned. No `done` is issued, and the tx trigger stays low.
- Request seen in IDLE at cycle 0. Then:
  - `grant` and `busy` rise at cycle 1.
  - `tx_start` is high at cycle 2.
  - WAIT covers cycles 3 .. 2+FRAME_BITS*D.
  - `done` is high at cycle 3+FRAME_BITS*D.
  - IDLE at cycle 4+FRAME_BITS*D.
- Back-to-back frame period: FRAME_BITS*D + 4 cycles. The next `grant` comes at the earliest at cycle 5+FRAME_BITS*D.
- All outputs are registered. There is no combinational path from `req` to any output.
- Counter wrap: the bit-period counter resets to 0 on reaching D-1. WAIT exits when the bit counter is at FRAME_BITS-1 and the bit-period counter is at D-1.

## Test plan
- Single request: `req`=4'b0010, `req_data`[15:8]=8'h0A, `baud_div`=10. Required:
  - `grant`=4'b0010 at cycle 1, `tx_data`=8'h0A.
  - `tx_start` pulse at cycle 2.
  - `done`=4'b0010 at cycle 113.
  - `busy` high over cycles 1..113.
- Fairness: all four `req` held high continuously, `baud_div`=1. Required:
  - Grant order 0,1,2,3,0.
  - Successive grants exactly 15 cycles apart.
  - Each `done` matches the owner's index.
- Pointer wrap: grant requester 3 alone, then `req`=4'b1001. Requester 0 is granted next, then requester 3.
- Divider edge cases:
  - `baud_div`=0 gives the same timing as 1 (`done` at cycle 14).
  - Changing `baud_div` from 10 to 2 during WAIT leaves `done` at cycle 113.
- Cancel: `req` pulses high for one cycle while busy, then drops. No grant issued; FSM returns to IDLE after DONE.
- Reset mid-WAIT: assert `rst_n`=0 at cycle 50 of a frame. All outputs are 0 in the same cycle, and no `done` is issued. After release, a pending `req[2]` is granted and its frame completes normally.
